// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the issue controller FSM states.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_CMP = 4'b1000;
  localparam logic [3:0] OP_NOP = 4'b1111;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StResp
  } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with full/empty/count; head entry is presented combinationally on rdata_o.
module cmd_fifo #(
  parameter int unsigned Width = 20,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AddrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_cmd_issue.sv
// Buffers ALU commands, issues them one at a time with a programmable hold, and
// returns the captured result and flags over a valid/ready response port.
module alu_cmd_issue
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HOLD  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [WIDTH-1:0]        cmd_a,
  input  logic [WIDTH-1:0]        cmd_b,
  input  logic [3:0]              cmd_op,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  output logic [3:0]              alu_opcode,
  input  logic [WIDTH-1:0]        alu_result,
  input  logic                    alu_carry,
  input  logic                    alu_zero,
  input  logic                    alu_overflow,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_result,
  output logic                    rsp_carry,
  output logic                    rsp_zero,
  output logic                    rsp_overflow,
  output logic [3:0]              rsp_op,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int unsigned DataW = 2 * WIDTH + 4;
  localparam int unsigned HoldW = (HOLD > 1) ? $clog2(HOLD) : 1;

  state_e             state_q, state_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [WIDTH-1:0]   alu_a_q, alu_b_q, rsp_result_q;
  logic [3:0]         alu_op_q, rsp_op_q;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_carry_q, rsp_zero_q, rsp_overflow_q;
  logic               pop, capture, full, empty, push;
  logic [DataW-1:0]   head;

  assign push      = cmd_valid && !full;
  assign cmd_ready = !full;

  cmd_fifo #(
    .Width (DataW),
    .Depth (DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .wdata_i ({cmd_a, cmd_b, cmd_op}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    rsp_valid_d = rsp_valid_q;
    pop         = 1'b0;
    capture     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          hold_d  = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (hold_q == HoldW'(HOLD - 1)) state_d = StCapture;
        else                            hold_d  = hold_q + 1'b1;
      end
      StCapture: begin
        capture     = 1'b1;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        // Handshake and next pop share one edge to keep throughput at HOLD+2.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!empty) begin
            pop     = 1'b1;
            hold_d  = '0;
            state_d = StIssue;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      hold_q         <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= OP_NOP;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_op_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      rsp_valid_q <= rsp_valid_d;
      if (pop) {alu_a_q, alu_b_q, alu_op_q} <= head;
      if (capture) begin
        rsp_result_q   <= alu_result;
        rsp_carry_q    <= alu_carry;
        rsp_zero_q     <= alu_zero;
        rsp_overflow_q <= alu_overflow;
        rsp_op_q       <= alu_op_q;
      end
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_opcode   = alu_op_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_op       = rsp_op_q;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Scoreboard bench for alu_cmd_issue driving a registered behavioural ALU.
module tb_alu_cmd_issue;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [3:0] cmd_op = '0;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_opcode;
  logic       alu_carry, alu_zero, alu_overflow;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_result;
  logic       rsp_carry, rsp_zero, rsp_overflow;
  logic [3:0] rsp_op;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [14:0] sb[$];
  int hs_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_issue #(.WIDTH(8), .DEPTH(4), .HOLD(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow), .rsp_op(rsp_op), .fifo_count(fifo_count)
  );

  // Registered ALU; CMP gives 00 / FF / 01 for equal / less / greater, carry = borrow.
  logic [8:0] sum;
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result <= '0; alu_carry <= 1'b0; alu_zero <= 1'b0; alu_overflow <= 1'b0;
    end else begin
      alu_carry    <= 1'b0;
      alu_overflow <= 1'b0;
      case (alu_opcode)
        OP_ADD: begin
          alu_result   <= alu_a + alu_b;
          alu_carry    <= 9'(alu_a) + 9'(alu_b) > 9'd255;
          alu_overflow <= (alu_a[7] == alu_b[7]) && (8'(alu_a + alu_b) >> 7 != 8'(alu_a[7]));
          alu_zero     <= 8'(alu_a + alu_b) == 8'h00;
        end
        OP_SUB: begin
          alu_result   <= alu_a - alu_b;
          alu_carry    <= alu_a < alu_b;
          alu_overflow <= (alu_a[7] != alu_b[7]) && (8'(alu_a - alu_b) >> 7 != 8'(alu_a[7]));
          alu_zero     <= alu_a == alu_b;
        end
        OP_AND: begin alu_result <= alu_a & alu_b; alu_zero <= (alu_a & alu_b) == 0; end
        OP_OR:  begin alu_result <= alu_a | alu_b; alu_zero <= (alu_a | alu_b) == 0; end
        OP_XOR: begin alu_result <= alu_a ^ alu_b; alu_zero <= (alu_a ^ alu_b) == 0; end
        OP_CMP: begin
          alu_result <= (alu_a == alu_b) ? 8'h00 : (alu_a < alu_b) ? 8'hFF : 8'h01;
          alu_carry  <= alu_a < alu_b;
          alu_zero   <= alu_a == alu_b;
        end
        default: begin alu_result <= '0; alu_zero <= 1'b1; end
      endcase
    end
  end
  assign sum = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a response is consumed on the next rising edge when valid and ready.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got result %0h op %0h, none expected", rsp_result, rsp_op);
      end else begin
        chk("rsp", {rsp_result, rsp_carry, rsp_zero, rsp_overflow, rsp_op}, 32'(sb.pop_front()));
        hs_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                      input logic [7:0] r, input logic c, input logic z, input logic v);
    int n = 0;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("push_timeout", 32'(cmd_ready), 32'd1);
    sb.push_back({r, c, z, v, op});
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp_valid();
    int n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    if (n >= 50) chk("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin tick(); n++; end
    chk("drain", 32'(sb.size()), 32'd0);
    repeat (2) tick();
  endtask

  task automatic check_reset_state();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_alu_ab", {alu_a, alu_b}, 32'h0000);
    chk("rst_alu_op", 32'(alu_opcode), 32'hF);
    chk("rst_rsp", {rsp_result, rsp_carry, rsp_zero, rsp_overflow, rsp_op}, 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    check_reset_state();

    // Single ADD: response valid exactly after the fourth edge.
    push(8'h05, 8'h03, OP_ADD, 8'h08, 1'b0, 1'b0, 1'b0);
    tick();
    chk("issue_operands", {alu_a, alu_b, 4'h0, alu_opcode}, {8'h05, 8'h03, 4'h0, OP_ADD});
    chk("issue_count", 32'(fifo_count), 32'd0);
    tick(); chk("lat_n2", 32'(rsp_valid), 32'd0);
    tick(); chk("lat_n3", 32'(rsp_valid), 32'd0);
    tick(); chk("lat_n4", 32'(rsp_valid), 32'd1);
    drain();

    // Compare: equal then less-than.
    push(8'h2A, 8'h2A, OP_CMP, 8'h00, 1'b0, 1'b1, 1'b0);
    push(8'h10, 8'h20, OP_CMP, 8'hFF, 1'b1, 1'b0, 1'b0);
    drain();

    // Fill under back-pressure, then stall in RESP.
    rsp_ready = 1'b0;
    push(8'h80, 8'h80, OP_ADD, 8'h00, 1'b1, 1'b1, 1'b1);
    push(8'h03, 8'h05, OP_SUB, 8'hFE, 1'b1, 1'b0, 1'b0);
    push(8'hF0, 8'h3C, OP_AND, 8'h30, 1'b0, 1'b0, 1'b0);
    push(8'h00, 8'h00, OP_OR,  8'h00, 1'b0, 1'b1, 1'b0);
    push(8'hAA, 8'h55, OP_XOR, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("fill_count", 32'(fifo_count), 32'd4);
    chk("fill_ready", 32'(cmd_ready), 32'd0);
    wait_rsp_valid();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall", {rsp_valid, rsp_carry, rsp_overflow, rsp_result, alu_a, 5'(fifo_count)},
          {1'b1, 1'b1, 1'b1, 8'h00, 8'h80, 5'd4});
    end
    hs_cyc.delete();
    rsp_ready = 1'b1;
    drain();
    chk("hs_num", 32'(hs_cyc.size()), 32'd5);
    for (int i = 1; i < hs_cyc.size(); i++) chk("spacing", hs_cyc[i] - hs_cyc[i-1], 32'd4);

    // Simultaneous push and pop at count 2.
    rsp_ready = 1'b0;
    push(8'h11, 8'h22, OP_ADD, 8'h33, 1'b0, 1'b0, 1'b0);
    push(8'h40, 8'h01, OP_SUB, 8'h3F, 1'b0, 1'b0, 1'b0);
    push(8'h0F, 8'hF0, OP_OR,  8'hFF, 1'b0, 1'b0, 1'b0);
    wait_rsp_valid();
    chk("pp_count_before", 32'(fifo_count), 32'd2);
    cmd_valid = 1'b1; cmd_a = 8'h7F; cmd_b = 8'h01; cmd_op = OP_ADD;
    rsp_ready = 1'b1;
    sb.push_back({8'h80, 1'b0, 1'b0, 1'b1, OP_ADD});
    tick();
    cmd_valid = 1'b0;
    chk("pp_count_after", 32'(fifo_count), 32'd2);
    chk("pp_next_issue", {alu_a, alu_b, 4'h0, alu_opcode}, {8'h40, 8'h01, 4'h0, OP_SUB});
    drain();

    // Reset mid-ISSUE with three commands still buffered.
    rsp_ready = 1'b0;
    push(8'h01, 8'h01, OP_ADD, 8'h02, 1'b0, 1'b0, 1'b0);
    wait_rsp_valid();
    push(8'h01, 8'h02, OP_ADD, 8'h03, 1'b0, 1'b0, 1'b0);
    push(8'h05, 8'h06, OP_ADD, 8'h0B, 1'b0, 1'b0, 1'b0);
    push(8'h07, 8'h08, OP_ADD, 8'h0F, 1'b0, 1'b0, 1'b0);
    push(8'h09, 8'h0A, OP_ADD, 8'h13, 1'b0, 1'b0, 1'b0);
    rsp_ready = 1'b1;
    tick();
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    chk("pre_rst_issue", {alu_a, alu_b}, {16'h0, 8'h01, 8'h02});
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    check_reset_state();
    repeat (20) tick();
    chk("flush_quiet", 32'(rsp_valid), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
